usb_packet_buffer: RTL and testbench

Parametrised circular FIFO shared by the USB TX and RX data paths, replacing the fixed 64-byte linear buffer.
- Pointers wrap, so the buffer is reusable without a clear.
- Full/empty flags and sticky overflow/underflow error flags are provided.
- A mark/rewind pair lets the protocol controller replay an un-ACKed TX packet or drop a corrupt RX packet.
- Sits between the USB protocol FSMs (RX/TX packet side) and the AHB-lite slave (host data side).

---
 rtl/usb_buf_pkg.sv | 13 +
 rtl/usb_buf_mem.sv | 26 ++
 rtl/usb_packet_buffer.sv | 109 ++++++++++
 tb/tb_usb_packet_buffer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_buf_pkg.sv
// Shared types and defaults for the USB packet buffer.
// Imported by usb_buf_mem and usb_packet_buffer.
package usb_buf_pkg;

  localparam int USB_BUF_DEPTH_DEF = 64;
  localparam int USB_BUF_DW_DEF    = 8;

  typedef struct packed {
    logic ovf;
    logic unf;
  } usb_buf_err_t;

endpackage

// File: rtl/usb_buf_mem.sv
// DEPTH x DATA_W register file, one sync write port, one async read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read); array not reset.
module usb_buf_mem
  import usb_buf_pkg::*;
#(
  parameter int DATA_W = USB_BUF_DW_DEF,
  parameter int DEPTH  = USB_BUF_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/usb_packet_buffer.sv
// Circular FIFO shared by USB TX/RX paths with mark/rewind replay.
// Ports: two store and two get sides, mark/rewind, clear, status flags.
module usb_packet_buffer
  import usb_buf_pkg::*;
#(
  parameter int DATA_W = USB_BUF_DW_DEF,
  parameter int DEPTH  = USB_BUF_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              store_TX_data,
  input  logic [DATA_W-1:0] TX_data,
  input  logic              store_RX_packet_data,
  input  logic [DATA_W-1:0] RX_packet_data,
  input  logic              get_RX_data,
  input  logic              get_TX_packet_data,
  output logic [DATA_W-1:0] RX_data,
  output logic [DATA_W-1:0] TX_packet_data,
  input  logic              mark,
  input  logic              rewind,
  output logic [AW:0]       buffer_occupancy,
  output logic              full,
  output logic              empty,
  output logic              overflow_err,
  output logic              underflow_err,
  output logic              clear_done
);

  logic [AW:0]       wptr, rptr, mptr;
  logic [AW:0]       held, rptr_nxt, mptr_nxt;
  logic [DATA_W-1:0] rd_data, wr_data;
  logic              wr_req, rd_req, do_wr, do_pop;
  logic              armed;
  usb_buf_err_t      err;

  assign wr_req  = store_TX_data | store_RX_packet_data;
  assign rd_req  = get_RX_data | get_TX_packet_data;
  assign wr_data = store_RX_packet_data ? RX_packet_data : TX_data;

  assign held             = wptr - mptr;
  assign buffer_occupancy = wptr - rptr;
  assign full             = (held == (AW+1)'(DEPTH));
  assign empty            = (wptr == rptr);

  assign do_wr  = wr_req & ~full;
  assign do_pop = rd_req & ~empty & ~rewind;

  assign RX_data = (get_RX_data & ~empty) ? rd_data : '0;
  assign TX_packet_data =
    (get_TX_packet_data & ~get_RX_data & ~empty) ? rd_data : '0;

  assign overflow_err  = err.ovf;
  assign underflow_err = err.unf;

  assign rptr_nxt = rewind ? mptr : rptr + (AW+1)'(do_pop);

  // An explicit mark arms the packet start so it stays put while the
  // packet is popped; rewind disarms it and auto-follow resumes.
  always_comb begin
    mptr_nxt = mptr;
    if (rewind)
      mptr_nxt = mptr;
    else if (mark)
      mptr_nxt = rptr_nxt;
    else if (!armed && rptr == mptr)
      mptr_nxt = rptr_nxt;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr       <= '0;
      rptr       <= '0;
      mptr       <= '0;
      armed      <= 1'b0;
      err        <= '0;
      clear_done <= 1'b0;
    end else if (clear) begin
      wptr       <= '0;
      rptr       <= '0;
      mptr       <= '0;
      armed      <= 1'b0;
      err        <= '0;
      clear_done <= 1'b1;
    end else begin
      clear_done <= 1'b0;
      if (do_wr) wptr <= wptr + (AW+1)'(1);
      rptr    <= rptr_nxt;
      mptr    <= mptr_nxt;
      armed   <= rewind ? 1'b0 : (mark | armed);
      err.ovf <= err.ovf | (wr_req & full);
      err.unf <= err.unf | (rd_req & empty & ~rewind);
    end
  end

  usb_buf_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (do_wr & ~clear),
    .waddr(wptr[AW-1:0]),
    .wdata(wr_data),
    .raddr(rptr[AW-1:0]),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_usb_packet_buffer.sv
// Scoreboard bench for usb_packet_buffer (DEPTH 64, DATA_W 8).
// Reads are checked by a negedge monitor against a queue of expectations.
module tb_usb_packet_buffer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       clear;
  logic       store_TX_data;
  logic [7:0] TX_data;
  logic       store_RX_packet_data;
  logic [7:0] RX_packet_data;
  logic       get_RX_data;
  logic       get_TX_packet_data;
  logic [7:0] RX_data;
  logic [7:0] TX_packet_data;
  logic       mark;
  logic       rewind;
  logic [6:0] buffer_occupancy;
  logic       full;
  logic       empty;
  logic       overflow_err;
  logic       underflow_err;
  logic       clear_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         rx;
    logic [7:0] d;
  } exp_t;

  exp_t q[$];
  exp_t e;

  usb_packet_buffer dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .clear               (clear),
    .store_TX_data       (store_TX_data),
    .TX_data             (TX_data),
    .store_RX_packet_data(store_RX_packet_data),
    .RX_packet_data      (RX_packet_data),
    .get_RX_data         (get_RX_data),
    .get_TX_packet_data  (get_TX_packet_data),
    .RX_data             (RX_data),
    .TX_packet_data      (TX_packet_data),
    .mark                (mark),
    .rewind              (rewind),
    .buffer_occupancy    (buffer_occupancy),
    .full                (full),
    .empty               (empty),
    .overflow_err        (overflow_err),
    .underflow_err       (underflow_err),
    .clear_done          (clear_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (n_rst && (get_RX_data || get_TX_packet_data)) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL read_unexpected rx=%0h tx=%0h",
                 RX_data, TX_packet_data);
      end else begin
        e = q.pop_front();
        if (e.rx) begin
          if (RX_data !== e.d || TX_packet_data !== 8'h00) begin
            bad++;
            $display("FAIL rx_read got rx=%0h tx=%0h want rx=%0h tx=0",
                     RX_data, TX_packet_data, e.d);
          end
        end else begin
          if (TX_packet_data !== e.d || RX_data !== 8'h00) begin
            bad++;
            $display("FAIL tx_read got tx=%0h rx=%0h want tx=%0h rx=0",
                     TX_packet_data, RX_data, e.d);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic st_tx(input logic [7:0] v);
    store_TX_data = 1'b1;
    TX_data = v;
    cyc();
    store_TX_data = 1'b0;
  endtask

  task automatic pop_tx(input logic [7:0] v);
    q.push_back('{1'b0, v});
    get_TX_packet_data = 1'b1;
    cyc();
    get_TX_packet_data = 1'b0;
  endtask

  task automatic pop_rx(input logic [7:0] v);
    q.push_back('{1'b1, v});
    get_RX_data = 1'b1;
    cyc();
    get_RX_data = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0;
    clear = 1'b0;
    store_TX_data = 1'b0;
    TX_data = 8'h00;
    store_RX_packet_data = 1'b0;
    RX_packet_data = 8'h00;
    get_RX_data = 1'b0;
    get_TX_packet_data = 1'b0;
    mark = 1'b0;
    rewind = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_occ", 32'(buffer_occupancy), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow_err), 0);
    chk("rst_unf", 32'(underflow_err), 0);
    chk("rst_cdone", 32'(clear_done), 0);
    n_rst = 1'b1;
    cyc();

    // fill, overflow
    for (int i = 0; i < 64; i++) st_tx(8'(i));
    chk("fill_occ", 32'(buffer_occupancy), 64);
    chk("fill_full", 32'(full), 1);
    chk("fill_ovf0", 32'(overflow_err), 0);
    st_tx(8'h40);
    chk("ovf_set", 32'(overflow_err), 1);
    chk("ovf_occ", 32'(buffer_occupancy), 64);

    // drain, underflow
    for (int i = 0; i < 64; i++) pop_tx(8'(i));
    chk("drain_empty", 32'(empty), 1);
    chk("drain_unf0", 32'(underflow_err), 0);
    pop_tx(8'h00);
    chk("unf_set", 32'(underflow_err), 1);
    chk("unf_occ", 32'(buffer_occupancy), 0);

    // clear mid-stream
    for (int i = 0; i < 20; i++) st_tx(8'(8'h50 + i));
    chk("pre_clr_occ", 32'(buffer_occupancy), 20);
    chk("pre_clr_ovf", 32'(overflow_err), 1);
    do_clear();
    chk("clr_occ", 32'(buffer_occupancy), 0);
    chk("clr_empty", 32'(empty), 1);
    chk("clr_ovf", 32'(overflow_err), 0);
    chk("clr_unf", 32'(underflow_err), 0);
    chk("clr_done1", 32'(clear_done), 1);
    cyc();
    chk("clr_done0", 32'(clear_done), 0);

    // wrap
    for (int i = 0; i < 40; i++) st_tx(8'(i));
    for (int i = 0; i < 40; i++) pop_tx(8'(i));
    for (int i = 0; i < 40; i++) begin
      st_tx(8'(8'hA0 + i));
      if (i == 30) chk("wrap_occ31", 32'(buffer_occupancy), 31);
    end
    chk("wrap_occ40", 32'(buffer_occupancy), 40);
    for (int i = 0; i < 40; i++) begin
      pop_tx(8'(8'hA0 + i));
      if (i == 9) chk("wrap_occ30", 32'(buffer_occupancy), 30);
    end
    chk("wrap_empty", 32'(empty), 1);

    // mark / rewind
    do_clear();
    mark = 1'b1;
    cyc();
    mark = 1'b0;
    for (int i = 0; i < 10; i++) st_tx(8'(8'h30 + i));
    for (int i = 0; i < 10; i++) pop_tx(8'(8'h30 + i));
    chk("mk_occ0", 32'(buffer_occupancy), 0);
    rewind = 1'b1;
    cyc();
    rewind = 1'b0;
    chk("rw_occ10", 32'(buffer_occupancy), 10);
    for (int i = 0; i < 53; i++) st_tx(8'(8'h80 + i));
    chk("rw_full0", 32'(full), 0);
    st_tx(8'h80 + 8'd53);
    chk("rw_full1", 32'(full), 1);
    chk("rw_occ64", 32'(buffer_occupancy), 64);
    chk("rw_ovf0", 32'(overflow_err), 0);
    for (int i = 0; i < 10; i++) pop_tx(8'(8'h30 + i));
    chk("rp_full0", 32'(full), 0);
    chk("rp_occ54", 32'(buffer_occupancy), 54);
    for (int i = 0; i < 54; i++) pop_tx(8'(8'h80 + i));
    chk("rp_empty", 32'(empty), 1);

    // dual store: RX side wins
    store_TX_data = 1'b1;
    TX_data = 8'h11;
    store_RX_packet_data = 1'b1;
    RX_packet_data = 8'h22;
    cyc();
    store_TX_data = 1'b0;
    store_RX_packet_data = 1'b0;
    chk("dual_occ", 32'(buffer_occupancy), 1);
    pop_rx(8'h22);
    chk("dual_empty", 32'(empty), 1);

    // same-cycle store+get, dual get
    for (int i = 0; i < 5; i++) st_tx(8'(8'h60 + i));
    q.push_back('{1'b0, 8'h60});
    store_TX_data = 1'b1;
    TX_data = 8'h70;
    get_TX_packet_data = 1'b1;
    cyc();
    store_TX_data = 1'b0;
    get_TX_packet_data = 1'b0;
    chk("sg_occ5", 32'(buffer_occupancy), 5);
    q.push_back('{1'b1, 8'h61});
    get_RX_data = 1'b1;
    get_TX_packet_data = 1'b1;
    cyc();
    get_RX_data = 1'b0;
    get_TX_packet_data = 1'b0;
    chk("dg_occ4", 32'(buffer_occupancy), 4);
    pop_tx(8'h62);
    pop_tx(8'h63);
    pop_tx(8'h64);
    pop_rx(8'h70);
    chk("sg_empty", 32'(empty), 1);

    // store+get while empty: get underflows
    chk("eg_unf0", 32'(underflow_err), 0);
    q.push_back('{1'b0, 8'h00});
    store_TX_data = 1'b1;
    TX_data = 8'h99;
    get_TX_packet_data = 1'b1;
    cyc();
    store_TX_data = 1'b0;
    get_TX_packet_data = 1'b0;
    chk("eg_unf1", 32'(underflow_err), 1);
    chk("eg_occ1", 32'(buffer_occupancy), 1);
    pop_tx(8'h99);

    // async reset mid-packet
    st_tx(8'h01);
    st_tx(8'h02);
    chk("ar_occ2", 32'(buffer_occupancy), 2);
    n_rst = 1'b0;
    #1;
    chk("ar_occ0", 32'(buffer_occupancy), 0);
    chk("ar_unf0", 32'(underflow_err), 0);
    chk("ar_empty", 32'(empty), 1);
    cyc();
    n_rst = 1'b1;
    cyc();

    chk("sb_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
